// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider controller.
// Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero short-circuit).
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [31:0] DBZ_QUO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on a WIDTH+1-bit partial remainder.
// Purely combinational so it can be checked exhaustively at small WIDTH.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   remNext,
  output logic [WIDTH-1:0] quoNext
);
  logic [WIDTH+1:0] shRem;
  logic             ge;

  always_comb begin
    shRem   = {rem, quo[WIDTH-1]};
    ge      = shRem >= {2'b00, divisor};
    remNext = ge ? (WIDTH+1)'(shRem - {2'b00, divisor})
                 : shRem[WIDTH:0];
    quoNext = {quo[WIDTH-2:0], ge};
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative DIV/DIVU controller for the execute stage; stalls F/D/E while busy.
// Optional: define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  divState_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             quoNeg;
  logic             remNeg;
  logic [WIDTH-1:0] hiR;
  logic [WIDTH-1:0] loR;
`ifndef DIV_ZERO_FAST_EN
  logic             dbz;
  logic [WIDTH-1:0] aRaw;
`endif

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             bZero;
  logic             accept;
  logic [WIDTH:0]   nxtRem;
  logic [WIDTH-1:0] nxtQuo;
  logic [WIDTH-1:0] remFix;
  logic [WIDTH-1:0] quoFix;

  div_step #(.WIDTH(WIDTH)) uStep (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .remNext (nxtRem),
    .quoNext (nxtQuo)
  );

  always_comb begin
    absA   = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    absB   = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    bZero  = (opb_i == '0);
    accept = (state == IDLE) && start_i && !annul_i;
    remFix = remNeg ? -nxtRem[WIDTH-1:0] : nxtRem[WIDTH-1:0];
    quoFix = quoNeg ? -nxtQuo : nxtQuo;
`ifndef DIV_ZERO_FAST_EN
    // Divide-by-zero runs the full iteration; the result is substituted here.
    if (dbz) begin
      remFix = aRaw;
      quoFix = {WIDTH{DBZ_QUO[0]}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      quoNeg  <= 1'b0;
      remNeg  <= 1'b0;
      hiR     <= '0;
      loR     <= '0;
`ifndef DIV_ZERO_FAST_EN
      dbz     <= 1'b0;
      aRaw    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem     <= '0;
            quo     <= absA;
            divisor <= absB;
            cnt     <= '0;
            quoNeg  <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            remNeg  <= signed_i & opa_i[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            if (bZero) begin
              hiR   <= opa_i;
              loR   <= {WIDTH{DBZ_QUO[0]}};
              state <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            dbz     <= bZero;
            aRaw    <= opa_i;
            state   <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            rem <= nxtRem;
            quo <= nxtQuo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              hiR   <= remFix;
              loR   <= quoFix;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state != IDLE);
  assign stall_o = (state == BUSY) || accept;
  assign ready_o = (state == DONE) && !annul_i;
  assign hi_o    = hiR;
  assign lo_o    = loR;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: vector table plus corner sequences.
// Honors DIV_ZERO_FAST_EN for divide-by-zero latency.
module tb_div_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic        stall_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  div_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .ready_o  (ready_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic runDiv(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi,
                        input logic [31:0] lo, input string tag);
    res_t r;
    int   lat;
    int   expLat;
    logic stallOk;
    expLat = (b == 0) ? DBZ_LAT : 33;
    r.hi = hi;
    r.lo = lo;
    sb.push_back(r);
    @(negedge clk);
    start_i = 1'b1;
    signed_i = sgn;
    opa_i = a;
    opb_i = b;
    #1;
    chk({tag, " stallT"}, 32'(stall_o), 32'd1);
    lat = 0;
    stallOk = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
      if (ready_o) break;
      if (!stall_o) stallOk = 1'b0;
    end
    chk({tag, " stallBusy"}, 32'(stallOk), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(expLat));
    if (ready_o) begin
      chk({tag, " stallDone"}, 32'(stall_o), 32'd0);
      r = sb.pop_front();
      chk({tag, " hi"}, hi_o, r.hi);
      chk({tag, " lo"}, lo_o, r.lo);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    // start_i stays high through DONE; the next cycle must be IDLE.
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk({tag, " idleAfter"}, 32'(busy_o | stall_o), 32'd0);
  endtask

  task automatic watchNoReady(input int n, input string tag);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (ready_o) cnt++;
    end
    chk(tag, 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vecs[3] = '{1'b0, 32'd5,          32'd0,        32'd5,        32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'd0,        32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 32'd3,          32'd10,       32'd3,        32'd0};
    vecs[7] = '{1'b1, 32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
    vecs[9] = '{1'b0, 32'hDEAD_BEEF,  32'h10,       32'hF,        32'h0DEA_DBEE};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", 32'(stall_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst ready", 32'(ready_o), 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      runDiv(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
             $sformatf("vec%0d", i));
    end

    // Annul during BUSY cycle 10, then a fresh divide.
    @(negedge clk);
    start_i = 1'b1;
    signed_i = 1'b0;
    opa_i = 32'd50;
    opb_i = 32'd5;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annulBusy stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annulBusy stallNext", 32'(stall_o), 32'd0);
    chk("annulBusy busyNext", 32'(busy_o), 32'd0);
    watchNoReady(40, "annulBusy noReady");
    runDiv(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, "afterAnnul");

    // Start with annul in IDLE is refused.
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    #1;
    chk("annulIdle stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    chk("annulIdle busy", 32'(busy_o), 32'd0);

    // Annul in DONE suppresses the ready pulse.
    @(negedge clk);
    start_i = 1'b1;
    opa_i = 32'd100;
    opb_i = 32'd7;
    repeat (33) @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annulDone busy", 32'(busy_o), 32'd1);
    chk("annulDone ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annulDone idle", 32'(busy_o), 32'd0);

    // Reset in BUSY cycle 20 aborts and clears results.
    @(negedge clk);
    start_i = 1'b1;
    opa_i = 32'd100;
    opb_i = 32'd7;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midRst busy", 32'(busy_o), 32'd0);
    chk("midRst stall", 32'(stall_o), 32'd0);
    chk("midRst hi", hi_o, 32'd0);
    chk("midRst lo", lo_o, 32'd0);
    watchNoReady(40, "midRst noReady");

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
